// File: rtl/cpu_reg_pc_stage.sv
// A/D/PC register stage of the LittleComputer datapath, with run control:
// IDLE until start, RUN until a "jump to self" halt idiom, then HALTED until reset.
module cpu_reg_pc_stage #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [WIDTH-1:0] mux_out,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             zr,
    input  logic             ng,
    input  logic             is_c,
    input  logic             load_a,
    input  logic             load_d,
    input  logic [2:0]       jmp,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             running,
    output logic             halted
);

    // Interface contract: there is no valid/ready handshake here. Every input is
    // sampled on each rising edge; updates happen only when upd = RUN & ~stall.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             running_q, halted_q;

    logic upd;
    logic take;
    logic halt_hit;

    always_comb begin
        upd      = (state_q == ST_RUN) & ~stall;
        take     = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
        // Unconditional jump whose target is the jump itself: the program's end.
        halt_hit = upd & take & (jmp == 3'b111) & (a_q == pc_q);

        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;

        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (halt_hit) state_d = ST_HALTED;
            default:   state_d = state_q;
        endcase

        if (upd) begin
            if (load_a) a_d = mux_out;
            if (load_d) d_d = alu_out;
            // Jump target is the pre-edge A value, even when A loads this edge.
            if (!halt_hit) pc_d = take ? a_q : pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            pc_q      <= RESET_PC;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            pc_q      <= pc_d;
            running_q <= (state_d == ST_RUN);
            halted_q  <= (state_d == ST_HALTED);
        end
    end

    assign a_out   = a_q;
    assign d_out   = d_q;
    assign pc_out  = pc_q;
    assign running = running_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_reg_pc_stage.sv
// Self-checking bench for cpu_reg_pc_stage: directed scenarios with constant
// expectations plus a randomized run compared against a behavioural model.
module tb_cpu_reg_pc_stage;

  logic        clk;
  logic        rst_n;
  logic        start, stall, zr, ng, is_c, load_a, load_d;
  logic [2:0]  jmp;
  logic [15:0] mux_out, alu_out;
  logic [15:0] a_out, d_out, pc_out;
  logic        running, halted;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = halted
  int          m_state;
  logic [15:0] m_a, m_d, m_pc;

  cpu_reg_pc_stage #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .mux_out(mux_out), .alu_out(alu_out), .zr(zr), .ng(ng), .is_c(is_c),
    .load_a(load_a), .load_d(load_d), .jmp(jmp),
    .a_out(a_out), .d_out(d_out), .pc_out(pc_out),
    .running(running), .halted(halted)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached got running want finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    start = 0; stall = 0; load_a = 0; load_d = 0;
    is_c = 0; jmp = 3'b000; zr = 0; ng = 0;
    mux_out = 16'($urandom); alu_out = 16'($urandom);
  endtask

  task automatic model_reset();
    m_state = 0; m_a = 16'h0; m_d = 16'h0; m_pc = 16'h0;
  endtask

  // One clock edge; the model advances from the inputs seen at that edge.
  task automatic step();
    int          n_state;
    logic [15:0] n_a, n_d, n_pc;
    bit          lt, eq, gt, want, stop;
    n_state = m_state; n_a = m_a; n_d = m_d; n_pc = m_pc;
    if (m_state == 0 && start) n_state = 1;
    if (m_state == 1 && !stall) begin
      lt   = ng; eq = zr; gt = !ng && !zr;
      want = is_c && ((jmp[2] && lt) || (jmp[1] && eq) || (jmp[0] && gt));
      stop = want && (jmp == 3'b111) && (m_a == m_pc);
      if (stop) n_state = 2;
      else if (want) n_pc = m_a;
      else n_pc = m_pc + 16'd1;
      if (load_a) n_a = mux_out;
      if (load_d) n_d = alu_out;
    end
    @(posedge clk);
    m_state = n_state; m_a = n_a; m_d = n_d; m_pc = n_pc;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Lands with pc_out = t and a_out = av, using a non-halting conditional jump.
  task automatic goto_pc(input logic [15:0] t, input logic [15:0] av);
    idle_inputs(); load_a = 1; mux_out = t - 16'd1; step();
    idle_inputs(); is_c = 1; jmp = 3'b011; zr = 1; step();
    idle_inputs(); load_a = 1; mux_out = av; step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_out !== 16'h0) begin failures++; $display("FAIL reset_pc got %h want 0000", pc_out); end
    checks++; if (a_out !== 16'h0 || d_out !== 16'h0) begin failures++; $display("FAIL reset_ad got a=%h d=%h want 0000", a_out, d_out); end
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL reset_flags got run=%b halt=%b want 0 0", running, halted); end
    rst_n = 1;
    step();
    checks++; if (running !== 1'b0 || pc_out !== 16'h0) begin failures++; $display("FAIL idle_hold got run=%b pc=%h want 0 0000", running, pc_out); end
    start = 1; step(); start = 0;
    checks++; if (running !== 1'b1 || pc_out !== 16'h0) begin failures++; $display("FAIL start got run=%b pc=%h want 1 0000", running, pc_out); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc_out !== 16'(i)) begin failures++; $display("FAIL free_run_%0d got %h want %h", i, pc_out, 16'(i)); end
    end
  endtask

  task automatic test_ad_load();
    idle_inputs(); load_a = 1; mux_out = 16'h1234; load_d = 1; alu_out = 16'hBEEF; step();
    checks++; if (a_out !== 16'h1234) begin failures++; $display("FAIL load_a got %h want 1234", a_out); end
    checks++; if (d_out !== 16'hBEEF) begin failures++; $display("FAIL load_d got %h want beef", d_out); end
    idle_inputs(); mux_out = 16'hFFFF; alu_out = 16'h0000; step();
    checks++; if (a_out !== 16'h1234 || d_out !== 16'hBEEF) begin failures++; $display("FAIL ad_hold got a=%h d=%h want 1234 beef", a_out, d_out); end
  endtask

  task automatic test_jump_matrix();
    logic [15:0] want;
    bit          lt, eq, gt;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 8; j++) begin
        for (int c = 0; c < 2; c++) begin
          goto_pc(16'd5, 16'h0040);
          jmp = 3'(j); is_c = (c == 1); zr = (f == 0); ng = (f == 1);
          lt = (f == 1); eq = (f == 0); gt = (f == 2);
          want = (c == 1 && ((j[2] && lt) || (j[1] && eq) || (j[0] && gt))) ? 16'h0040 : 16'h0006;
          step();
          checks++;
          if (pc_out !== want) begin
            failures++;
            $display("FAIL jump flags=%0d jmp=%0d is_c=%0d got %h want %h", f, j, c, pc_out, want);
          end
        end
      end
    end
  endtask

  task automatic test_hazard_stall();
    goto_pc(16'd7, 16'h0010);
    load_a = 1; mux_out = 16'h0099; load_d = 1; alu_out = 16'h7777;
    jmp = 3'b111; is_c = 1; stall = 1;
    step();
    checks++; if (pc_out !== 16'h0007 || a_out !== 16'h0010) begin failures++; $display("FAIL stall_hold got pc=%h a=%h want 0007 0010", pc_out, a_out); end
    checks++; if (d_out === 16'h7777) begin failures++; $display("FAIL stall_d got %h want unchanged", d_out); end
    stall = 0;
    step();
    checks++; if (pc_out !== 16'h0010) begin failures++; $display("FAIL hazard_pc got %h want 0010", pc_out); end
    checks++; if (a_out !== 16'h0099 || d_out !== 16'h7777) begin failures++; $display("FAIL hazard_ad got a=%h d=%h want 0099 7777", a_out, d_out); end
    idle_inputs();
  endtask

  task automatic test_wrap_halt();
    goto_pc(16'hFFFF, 16'h0001);
    step();
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL wrap got %h want 0000", pc_out); end
    goto_pc(16'd9, 16'd9);
    is_c = 1; jmp = 3'b010; zr = 1; step();
    checks++; if (pc_out !== 16'd9 || running !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL cond_self got pc=%h run=%b halt=%b want 0009 1 0", pc_out, running, halted); end
    goto_pc(16'd3, 16'd3);
    is_c = 1; jmp = 3'b111; zr = 1; stall = 1; step();
    checks++; if (halted !== 1'b0 || running !== 1'b1) begin failures++; $display("FAIL stalled_halt got run=%b halt=%b want 1 0", running, halted); end
    stall = 0; load_d = 1; alu_out = 16'h5A5A; load_a = 1; mux_out = 16'h0003;
    step();
    checks++; if (halted !== 1'b1 || running !== 1'b0) begin failures++; $display("FAIL halt_flags got run=%b halt=%b want 0 1", running, halted); end
    checks++; if (pc_out !== 16'd3) begin failures++; $display("FAIL halt_pc got %h want 0003", pc_out); end
    checks++; if (d_out !== 16'h5A5A) begin failures++; $display("FAIL halt_load_d got %h want 5a5a", d_out); end
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); start = 1; load_a = 1; is_c = 1; jmp = 3'b111; step();
    end
    idle_inputs();
    checks++; if (halted !== 1'b1 || pc_out !== 16'd3 || a_out !== 16'd3) begin failures++; $display("FAIL halt_sticky got halt=%b pc=%h a=%h want 1 0003 0003", halted, pc_out, a_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    idle_inputs(); start = 1; step();
    goto_pc(16'h0022, 16'h0100);
    load_d = 1; alu_out = 16'h1111; step();
    idle_inputs();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (pc_out !== 16'h0 || a_out !== 16'h0 || d_out !== 16'h0) begin failures++; $display("FAIL async_regs got pc=%h a=%h d=%h want 0000", pc_out, a_out, d_out); end
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL async_flags got run=%b halt=%b want 0 0", running, halted); end
    @(posedge clk); #1; rst_n = 1;
    load_a = 1; mux_out = 16'hABCD; step(); step();
    checks++; if (running !== 1'b0 || pc_out !== 16'h0 || a_out !== 16'h0) begin failures++; $display("FAIL post_reset_idle got run=%b pc=%h a=%h want 0 0000 0000", running, pc_out, a_out); end
    idle_inputs(); start = 1; step(); start = 0; step();
    checks++; if (running !== 1'b1 || pc_out !== 16'h1) begin failures++; $display("FAIL restart got run=%b pc=%h want 1 0001", running, pc_out); end
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_state == 2) halted_cycles++;
      if (halted_cycles > 4) begin
        halted_cycles = 0;
        do_reset();
      end
      start   = ($urandom_range(0, 7) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      load_a  = 1'($urandom);
      load_d  = 1'($urandom);
      mux_out = ($urandom_range(0, 3) == 0) ? m_pc + 16'd1 : 16'($urandom);
      alu_out = 16'($urandom);
      jmp     = 3'($urandom_range(0, 7));
      is_c    = 1'($urandom);
      zr      = 1'($urandom);
      ng      = 1'($urandom);
      step();
      checks++; if (a_out !== m_a) begin failures++; $display("FAIL rand_a cycle %0d got %h want %h", i, a_out, m_a); end
      checks++; if (d_out !== m_d) begin failures++; $display("FAIL rand_d cycle %0d got %h want %h", i, d_out, m_d); end
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rand_pc cycle %0d got %h want %h", i, pc_out, m_pc); end
      checks++; if (running !== (m_state == 1)) begin failures++; $display("FAIL rand_running cycle %0d got %b want %b", i, running, m_state == 1); end
      checks++; if (halted !== (m_state == 2)) begin failures++; $display("FAIL rand_halted cycle %0d got %b want %b", i, halted, m_state == 2); end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    test_reset();
    test_ad_load();
    test_jump_matrix();
    test_hazard_stall();
    test_wrap_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
